// File: rtl/rgb_colour_sequencer_if.sv
// ---------------------------------------------------------------------------
// rgb_colour_sequencer_if
// Control and colour-output bundle between the doorbell controller and the
// RGB colour sequencer.
//   button : start/pause toggle level (debounced, clk-synchronous)
//   step   : single-colour advance request, honoured in PAUSE only
//   stop   : synchronous return to IDLE
//   rgb    : 24-bit colour word {R,G,B}
//   sel    : 1 selects the sequencer colour, 0 selects white downstream
//   colour : colour index, 1..6
// master = controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface rgb_colour_sequencer_if;
    logic        button;
    logic        step;
    logic        stop;
    logic [23:0] rgb;
    logic        sel;
    logic [2:0]  colour;

    modport master (
        output button, step, stop,
        input  rgb, sel, colour
    );

    modport slave (
        input  button, step, stop,
        output rgb, sel, colour
    );
endinterface

// File: rtl/rgb_colour_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_colour_sequencer
// Steps a colour index 1..6 through a fixed RGB table at a rate of one colour
// per HOLD_CYCLES clocks, under start/pause (button edge), step and stop
// control. All outputs are registered; there is no input-to-output
// combinational path.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rgb_colour_sequencer_if.slave (button/step/stop in,
//           rgb/sel/colour out)
// ---------------------------------------------------------------------------
module rgb_colour_sequencer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rgb_colour_sequencer_if.slave         bus
);

    localparam int PW = $clog2(HOLD_CYCLES);
    localparam logic [PW-1:0] PRESC_TC = PW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [2:0]    colour_q, colour_d;
    logic [23:0]   rgb_q,    rgb_d;
    logic          sel_q,    sel_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic          btn_q;

    logic          btn_rise;
    logic          advance;
    logic [2:0]    colour_nxt;

    function automatic logic [23:0] col2rgb(input logic [2:0] c);
        case (c)
            3'd1:    col2rgb = 24'h0000FF;
            3'd2:    col2rgb = 24'h00FF00;
            3'd3:    col2rgb = 24'h00FFFF;
            3'd4:    col2rgb = 24'hFF0000;
            3'd5:    col2rgb = 24'hFF00FF;
            3'd6:    col2rgb = 24'hFFFF00;
            default: col2rgb = 24'h0000FF;
        endcase
    endfunction

    assign btn_rise   = bus.button & ~btn_q;
    // 6 wraps to 1; 0 and 7 are unreachable.
    assign colour_nxt = (colour_q >= 3'd6) ? 3'd1 : colour_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        colour_d = colour_q;
        presc_d  = presc_q;
        advance  = 1'b0;

        if (bus.stop) begin
            state_d  = ST_IDLE;
            colour_d = 3'd1;
            presc_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (btn_rise) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (presc_q == PRESC_TC) begin
                        advance = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // Prescaler value carried into PAUSE is irrelevant:
                    // it is cleared on resume.
                    if (btn_rise) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    advance = bus.step;
                    if (btn_rise) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    colour_d = 3'd1;
                    presc_d  = '0;
                end
            endcase
            if (advance) begin
                colour_d = colour_nxt;
            end
        end

        // rgb and sel are registered from next-state so they move on the
        // same edge as colour/state.
        rgb_d = col2rgb(colour_d);
        sel_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            colour_q <= 3'd1;
            rgb_q    <= 24'h0000FF;
            sel_q    <= 1'b0;
            presc_q  <= '0;
            // Held-high button at reset release must not look like an edge.
            btn_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
            rgb_q    <= rgb_d;
            sel_q    <= sel_d;
            presc_q  <= presc_d;
            btn_q    <= bus.button;
        end
    end

    assign bus.rgb    = rgb_q;
    assign bus.sel    = sel_q;
    assign bus.colour = colour_q;

endmodule

// File: tb/tb_rgb_colour_sequencer.sv
module tb_rgb_colour_sequencer;

    logic clk;
    logic rst_n;

    rgb_colour_sequencer_if bus ();

    rgb_colour_sequencer #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       button;
        logic       step;
        logic       stop;
        logic [2:0] exp_col;
        logic       exp_sel;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    function automatic logic [23:0] ref_rgb(input logic [2:0] c);
        case (c)
            3'd1:    return 24'h0000FF;
            3'd2:    return 24'h00FF00;
            3'd3:    return 24'h00FFFF;
            3'd4:    return 24'hFF0000;
            3'd5:    return 24'hFF00FF;
            3'd6:    return 24'hFFFF00;
            default: return 24'hXXXXXX;
        endcase
    endfunction

    task automatic add(input logic b, input logic s, input logic st,
                       input logic [2:0] col, input logic sl);
        vec_t v;
        v.button = b; v.step = s; v.stop = st; v.exp_col = col; v.exp_sel = sl;
        vecs.push_back(v);
    endtask

    task automatic add_hold(input int n, input logic [2:0] col, input logic sl);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, col, sl);
    endtask

    task automatic chk(input string name, input logic [2:0] col, input logic sl);
        checks++;
        if (bus.colour !== col || bus.sel !== sl || bus.rgb !== ref_rgb(col)) begin
            failures++;
            $display("FAIL %s: got colour=%0d sel=%0b rgb=%06h, want colour=%0d sel=%0b rgb=%06h",
                     name, bus.colour, bus.sel, bus.rgb, col, sl, ref_rgb(col));
        end
    endtask

    task automatic cycle(input logic b, input logic s, input logic st);
        bus.button = b;
        bus.step   = s;
        bus.stop   = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n      = 1'b0;
        bus.button = 1'b0;
        bus.step   = 1'b0;
        bus.stop   = 1'b0;

        // IDLE, step ignored, start, step ignored in RUN
        add(0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0);
        add(1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1);
        add(0, 1, 0, 1, 1);
        add(0, 0, 0, 1, 1);
        // Run cadence: advance every 4 edges, 2..6 then wrap to 1, then 2
        add_hold(4, 2, 1);
        add_hold(4, 3, 1);
        add_hold(4, 4, 1);
        add_hold(4, 5, 1);
        add_hold(4, 6, 1);
        add_hold(4, 1, 1);
        add_hold(4, 2, 1);
        // Colour 3, pause with prescaler moving to 2
        add(0, 0, 0, 3, 1);
        add(0, 0, 0, 3, 1);
        add(1, 0, 0, 3, 1);
        add_hold(10, 3, 1);
        // Steps 4,5,6 then wrap to 1
        add(0, 1, 0, 4, 1);
        add(0, 0, 0, 4, 1);
        add(0, 1, 0, 5, 1);
        add(0, 1, 0, 6, 1);
        add(0, 1, 0, 1, 1);
        // Resume: next advance 4 edges after resume edge
        add(1, 0, 0, 1, 1);
        add_hold(3, 1, 1);
        add(0, 0, 0, 2, 1);
        add_hold(3, 2, 1);
        // Button on terminal count: advance and pause
        add(1, 0, 0, 3, 1);
        add_hold(5, 3, 1);
        // Step + button in PAUSE: advance, RUN with prescaler 0
        add(1, 1, 0, 4, 1);
        add_hold(3, 4, 1);
        add(0, 0, 0, 5, 1);
        // Stop with button edge and step
        add(1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0);

        #12;
        chk("reset_state", 3'd1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].button, vecs[i].step, vecs[i].stop);
            chk($sformatf("vec%0d", i), vecs[i].exp_col, vecs[i].exp_sel);
        end

        // Stop from PAUSE at colour 5, then restart
        cycle(1, 0, 0);
        chk("run_start", 3'd1, 1'b1);
        repeat (15) cycle(0, 0, 0);
        chk("run_col4", 3'd4, 1'b1);
        cycle(0, 0, 0);
        chk("run_col5", 3'd5, 1'b1);
        cycle(1, 0, 0);
        chk("pause_col5", 3'd5, 1'b1);
        cycle(0, 0, 0);
        chk("pause_hold5", 3'd5, 1'b1);
        cycle(0, 0, 1);
        chk("stop_pause", 3'd1, 1'b0);
        cycle(1, 0, 0);
        chk("restart", 3'd1, 1'b1);
        repeat (3) cycle(0, 0, 0);
        chk("restart_hold", 3'd1, 1'b1);
        cycle(0, 0, 0);
        chk("restart_adv", 3'd2, 1'b1);
        repeat (7) cycle(0, 0, 0);
        chk("run_col3", 3'd3, 1'b1);
        cycle(0, 0, 0);
        chk("run_col4b", 3'd4, 1'b1);

        // Asynchronous reset mid-RUN, released with button held
        #3;
        bus.button = 1'b1;
        rst_n      = 1'b0;
        #1;
        chk("async_reset", 3'd1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        repeat (3) cycle(1, 0, 0);
        chk("held_button_idle", 3'd1, 1'b0);
        cycle(0, 0, 0);
        chk("idle_after_release", 3'd1, 1'b0);
        cycle(1, 0, 0);
        chk("start_after_reset", 3'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_colour_sequencer.md
# rgb_colour_sequencer

Upstream stage of the doorbell light output path. It steps a 3-bit colour index through six fixed RGB colours at a programmable rate, under start/pause/step/stop control. It drives the 24-bit `rgb` word and the `sel` line that the downstream light multiplexer uses to choose between this colour and white. When the sequencer is idle, `sel` is 0, so the light shows white.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: clock cycles each colour is held in RUN. Legal range is 2 to 65535. The prescaler width is `$clog2(HOLD_CYCLES)`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `button` in 1: start/pause toggle. Level input, already debounced and synchronous to `clk`. Acts on its rising edge only.
- `step` in 1: advances one colour per cycle it is high, in PAUSE only.
- `stop` in 1: synchronous return to IDLE.
- `rgb` out 24: registered colour word, {R[7:0], G[7:0], B[7:0]}.
- `sel` out 1: registered. 1 in RUN or PAUSE, 0 in IDLE.
- `colour` out 3: registered colour index, always in the range 1..6.

## Operation
- **Colour table**, fixed:
  - 1 = 0x0000FF
  - 2 = 0x00FF00
  - 3 = 0x00FFFF
  - 4 = 0xFF0000
  - 5 = 0xFF00FF
  - 6 = 0xFFFF00
- **Index sequence:** 1→2→3→4→5→6→1. Values 0 and 7 are never produced. `rgb` always equals table[`colour`]; both update on the same edge.
- **Edge detect:** `btn_q` is the registered `button`. A rising edge is `button & ~btn_q`. `btn_q` resets to 1, so a button already held at reset release does not start the sequencer.
- **States** (IDLE, RUN, PAUSE):
  - IDLE: rising edge → RUN. `step` is ignored.
  - RUN: prescaler counts 0..HOLD_CYCLES-1. At terminal count the index advances and the prescaler wraps to 0. Rising edge → PAUSE. `step` is ignored.
  - PAUSE: index and prescaler are held. Each cycle with `step`=1 advances the index once. Rising edge → RUN.
  - Any state: `stop`=1 → IDLE, with `colour`=1 and prescaler=0.
- **Prescaler:**
  - Cleared to 0 on every entry to RUN.
  - Not cleared when RUN → PAUSE; it is cleared on resume instead.
  - Held at 0 in IDLE.
- **Priority:** `stop` > button edge > advance (terminal count or `step`).
- **Simultaneous events:**
  - Terminal count and button edge in the same RUN cycle: the index still advances, and the state goes to PAUSE.
  - `step` and button edge in the same PAUSE cycle: the index advances, and the state goes to RUN with prescaler 0.
  - `stop` together with any other input: result is IDLE, `colour`=1, no advance.
- **Reset** (asynchronous, any time, including mid-RUN):
  - state = IDLE
  - `colour` = 1
  - `rgb` = 0x0000FF
  - `sel` = 0
  - prescaler = 0
  - `btn_q` = 1
- Reset release is synchronous in effect: the first state change is on the first `clk` edge with `rst_n`=1.

## Timing
- Button edge sampled at edge N → `sel`=1 after edge N. First advance at edge N+HOLD_CYCLES, then one advance every HOLD_CYCLES edges.
- A step pulse sampled at edge N in PAUSE → new `colour`/`rgb` valid after edge N. Latency is 1 cycle.
- `stop` sampled at edge N → `sel`=0 and `colour`=1 after edge N.
- Resume from PAUSE at edge N → next advance at edge N+HOLD_CYCLES.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with `colour`=4 → outputs immediately `colour`=1, `rgb`=0x0000FF, `sel`=0. Release with `button` held high → stays IDLE.
- **Run cadence** (HOLD_CYCLES=4): one button pulse → `sel`=1. `colour` goes 2, 3, 4, 5, 6, 1 at 4-cycle spacing, with `rgb` matching the table each cycle. `colour` never shows 0 or 7.
- **Pause/step:** pause at `colour`=3, hold 10 cycles → unchanged. Three single-cycle `step` pulses → 4, 5, 6. A fourth `step` → 1 (wrap). `step` in IDLE or RUN → no effect.
- **Resume timing:** pause with prescaler at 2, then resume → next advance exactly 4 cycles after the resume edge, not 2.
- **Simultaneous events:**
  - Button edge on the terminal-count cycle → `colour` advances and the state becomes PAUSE.
  - `stop` with button edge and `step` → IDLE, `colour`=1, `sel`=0.
- **Stop from PAUSE:** at `colour`=5, assert `stop` → `colour`=1, `rgb`=0x0000FF, `sel`=0 next cycle. A new button edge restarts with the first advance to 2 after 4 cycles.
